dmem_bus_if: RTL
================

# dmem_bus_if

Memory-stage data-bus interface for the RV32I pipeline. It sits directly downstream of the load/store byte-lane aligner. It takes the aligner's lane-aligned store data and byte mask plus the effective address, runs a request/grant/response transaction on the data-memory bus, and returns the raw read word to the aligner for extraction. It stalls the pipeline until the transaction completes, and flags bus errors and timeouts.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+RSP before the access is aborted; range 1..65535.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- load  in  1  MEM-stage load; held stable while stall=1
- store  in  1  MEM-stage store; held stable while stall=1
- addr  in  32  effective byte address
- masking  in  4  byte enables from the aligner; used for stores only
- wdata  in  32  lane-aligned store data from the aligner
- rdata  out  32  registered full read word; feeds the aligner's load-data input
- stall  out  1  freezes IF..MEM while high
- fault  out  1  one-cycle pulse marking an aborted access
- misalign  out  1  one-cycle pulse marking a misaligned access; see Configuration
- bus_req  out  1  request, held until bus_gnt
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, equal to {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  write data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response valid; acknowledges both reads and writes
- bus_rdata  in  32  read data, qualified by bus_rvalid
- bus_err  in  1  error, qualified by bus_rvalid

## Operation
- The FSM has four states: IDLE, REQ, RSP, DONE.
- IDLE: if load|store, capture addr/masking/wdata, set bus_we=store, go REQ.
  - If load and store are both high, the store wins.
  - Loads drive bus_be=4'b1111.
  - A store with masking==4'b0000 issues no bus transaction; go DONE with fault=0.
- REQ: bus_req=1. Stay until bus_gnt, then go RSP. A bus_rvalid seen in REQ is ignored.
- RSP: bus_req=0. On bus_rvalid, go DONE.
  - On a load with bus_err=0, capture bus_rdata into rdata.
  - On bus_err=1, set fault and leave rdata unchanged.
  - A bus_gnt seen in RSP is ignored.
- DONE: stall=0 for exactly one cycle so the pipeline advances. fault/misalign pulse here if set. Go IDLE.
- stall = (IDLE & (load|store)) | REQ | RSP. This is combinational, so the instruction cannot leave MEM in its first cycle.
- Timeout: a counter clears on entry to REQ and increments in REQ and RSP. At count==TIMEOUT-1 with no completing event, go DONE with fault=1 and bus_req dropped. Any late bus_rvalid arriving in DONE or IDLE is discarded.
- rdata changes only on a successful load completion.
- Outputs held in registers: bus_addr, bus_be, bus_wdata, bus_we. They stay stable from REQ through RSP.
- Reset values: state=IDLE, rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, fault=0, misalign=0, counter=0. stall reset value is 0 unless load|store.
- Reset mid-transaction: immediate return to IDLE with bus_req low. No completion is reported.

## Timing
- Best case (gnt in the first REQ cycle, rvalid the cycle after): cycle 0 IDLE, 1 REQ, 2 RSP, 3 DONE. stall is high for cycles 0–2, and rdata is valid from cycle 3.
- Each wait cycle on gnt or rvalid adds one stall cycle.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle right after DONE, with no extra bubble beyond DONE.
- Worst case stall is TIMEOUT+1 cycles.

## Configuration
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: in IDLE the access is misaligned if load&addr[1:0]!=0, or store&masking==4'b0110, or store&masking==4'b1111&addr[1:0]!=0.
  - A misaligned access issues no bus transaction and goes directly to DONE with fault=1 and misalign=1.
  - rdata is unchanged.
- Undefined: no check is made; every access is issued as given. misalign is tied to 0.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE/REQ/RSP/DONE);
  - BE_FULL=4'b1111;
  - a misalignment-check function shared with any future MMU.
- One sub-module, dmem_wdog: a loadable timeout counter with clear/enable inputs and an expired output, parameterised by TIMEOUT.

## Test plan
- Load addr=32'h104, gnt immediate, rvalid next cycle with rdata=32'hDEADBEEF → stall high for 3 cycles, bus_be=4'hF, bus_addr=32'h104; rdata=32'hDEADBEEF in the DONE cycle.
- Store addr=32'h203, masking=4'b1000, wdata=32'hAA000000, gnt delayed 2 cycles → bus_we=1, bus_be=4'b1000, bus_addr=32'h200 held through the wait; stall high for 5 cycles.
- Load answered with bus_rvalid and bus_err=1 → fault pulses 1 cycle in DONE; rdata keeps its previous value.
- TIMEOUT=4, gnt never asserted → DONE after 4 REQ cycles, fault=1, bus_req low; a bus_rvalid injected afterwards is ignored.
- rst_n low during RSP → bus_req=0 and state IDLE immediately; after release, a new load completes normally.
- With DMEM_MISALIGN_TRAP_EN: load addr=32'h102 → no bus_req, fault=misalign=1 in the cycle after detection. Without the macro: the same load issues bus_addr=32'h100.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory bus interface.
// The misalignment check lives here so a future MMU can reuse it.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } dmem_state_e;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // Watchdog counter width; covers the full TIMEOUT range of 1..65535.
    localparam int unsigned TIMER_W = 16;

    // A store wins over a load, so when both are raised only the store rules apply.
    function automatic logic is_misaligned(input logic       load,
                                           input logic       store,
                                           input logic [1:0] addr_lo,
                                           input logic [3:0] mask);
        logic mis;
        if (store) begin
            mis = (mask == 4'b0110) || ((mask == BE_FULL) && (addr_lo != 2'b00));
        end else begin
            mis = load && (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/dmem_wdog.sv
// Transaction watchdog: a counter that is cleared at the start of a bus
// access, advances while the access is outstanding, and flags expiry on
// its last permitted cycle.
module dmem_wdog
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Clear has priority so a fresh access always starts counting from zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/dmem_bus_if.sv
// MEM-stage data-bus interface: turns an aligned load/store into a
// req/gnt/rvalid bus transaction, stalls the pipeline until it finishes,
// and reports bus errors and timeouts as a one-cycle fault pulse.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN traps misaligned accesses
// in IDLE instead of issuing them.
module dmem_bus_if
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] addr,
    input  logic [3:0]  masking,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    dmem_state_e state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic        fault_q, fault_d;
    logic        misalign_q, misalign_d;
    logic        bad_access;
    logic        expired;
    logic        wdog_clear;
    logic        wdog_en;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad_access = is_misaligned(load, store, addr[1:0], masking);
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr[1:0];
    assign bad_access     = 1'b0;
`endif

    dmem_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wdog_clear),
        .enable_i  (wdog_en),
        .expired_o (expired)
    );

    // Next-state logic; fault/misalign only ever get set on the way into DONE.
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        fault_d    = 1'b0;
        misalign_d = 1'b0;
        wdog_clear = 1'b0;
        wdog_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load || store) begin
                    addr_d  = {addr[31:2], 2'b00};
                    wdata_d = wdata;
                    we_d    = store;
                    be_d    = store ? masking : BE_FULL;
                    if (bad_access) begin
                        state_d    = DONE;
                        fault_d    = 1'b1;
                        misalign_d = 1'b1;
                    end else if (store && (masking == BE_NONE)) begin
                        state_d = DONE;
                    end else begin
                        state_d    = REQ;
                        wdog_clear = 1'b1;
                    end
                end
            end
            REQ: begin
                wdog_en = 1'b1;
                if (expired) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                end else if (bus_gnt) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                wdog_en = 1'b1;
                if (bus_rvalid) begin
                    state_d = DONE;
                    if (bus_err) begin
                        fault_d = 1'b1;
                    end else if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                end else if (expired) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers; reset abandons any open access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            fault_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            fault_q    <= fault_d;
            misalign_q <= misalign_d;
        end
    end

    assign stall     = ((state_q == IDLE) && (load || store)) ||
                       (state_q == REQ) || (state_q == RSP);
    assign bus_req   = (state_q == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign misalign  = misalign_q;

endmodule
